seq_mul32: RTL and testbench

Sequential 32x32 radix-2 shift-add multiplier producing a 64-bit product, with signed and unsigned modes. It sits in the execute path directly upstream of the 64-bit result select mux, which chooses between this product and the other 64-bit datapath result. Operands are captured on a start pulse and the product is computed over 32 iteration cycles. The product stays registered and stable until the next operation completes.

---
 rtl/seq_mul32.sv | 146 ++++++++++++++
 tb/tb_seq_mul32.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul32.sv
// seq_mul32: sequential radix-2 shift-add multiplier, N x N -> 2N bits.
// Operands are captured on start in IDLE, magnitudes are multiplied over
// N CALC cycles, and the sign is applied in FIN when the product register
// is written. busy, done and product are all registered outputs.
module seq_mul32 #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0]  LAST_COUNT = CW'(N - 1);
  localparam logic [CW-1:0]  COUNT_ONE  = CW'(1);
  localparam logic [2*N-1:0] WIDE_ONE   = (2*N)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          busy_nxt_s;
  logic          done_nxt_s;
  logic [N-1:0]  mcand_r;
  logic [N-1:0]  hi_r;
  logic [N-1:0]  lo_r;
  logic          neg_r;
  logic [CW-1:0] count_r;
  logic [N:0]    sum_s;

  // Magnitude of an operand; in signed mode the most negative value maps
  // to 2^(N-1), which still fits as an unsigned N-bit number.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v,
                                             input logic         is_signed);
    logic [N-1:0] m;
    if (is_signed && v[N-1]) begin
      m = ~v + N'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == LAST_COUNT) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIN: begin
        state_nxt_s = IDLE;
        done_nxt_s  = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // Partial-sum adder; the carry out becomes the top bit shifted into hi.
  always_comb begin
    if (lo_r[0]) begin
      sum_s = {1'b0, hi_r} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, hi_r};
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
    end
  end

  // Datapath: operand capture, shift-add iterations, signed product write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r <= {N{1'b0}};
      hi_r    <= {N{1'b0}};
      lo_r    <= {N{1'b0}};
      neg_r   <= 1'b0;
      count_r <= {CW{1'b0}};
      product <= {(2*N){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r <= magnitude(a, signed_op);
            lo_r    <= magnitude(b, signed_op);
            hi_r    <= {N{1'b0}};
            neg_r   <= signed_op & (a[N-1] ^ b[N-1]);
            count_r <= {CW{1'b0}};
          end else begin
            mcand_r <= mcand_r;
          end
        end
        CALC: begin
          {hi_r, lo_r} <= {sum_s, lo_r[N-1:1]};
          count_r      <= count_r + COUNT_ONE;
        end
        FIN: begin
          if (neg_r) begin
            product <= ~{hi_r, lo_r} + WIDE_ONE;
          end else begin
            product <= {hi_r, lo_r};
          end
        end
        default: begin
          product <= product;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul32.sv
// tb_seq_mul32: directed vector table plus hand-written sequences for the
// ignored-start, mid-operation reset and back-to-back cases, followed by a
// short random sweep against the native 64-bit product.
module tb_seq_mul32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int passed;
  int total;
  int done_seen;
  int accepted;
  logic [63:0] last_p;

  typedef struct {
    string       name;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];

  seq_mul32 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts done pulses over the whole run.
  always @(posedge clk) begin
    if (done) done_seen <= done_seen + 1;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One operation started at the next edge; poke >= 0 pulses a second start
  // (7*9) so that it is sampled at edge E(poke).
  task automatic run_op(input string nm, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input int poke);
    int lat;
    bit held;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1; signed_op = s; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; signed_op = ~s;
    lat = 0; held = 1'b1; busy_ok = 1'b1;
    while (!done && lat < 60) begin
      if (product !== last_p) held = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == poke - 1) begin
        start = 1'b1; a = 32'd7; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    accepted++;
    check({nm, " latency"}, 64'(lat), 64'd33);
    check({nm, " busy held"}, {63'd0, busy_ok}, 64'd1);
    check({nm, " product stable"}, {63'd0, held}, 64'd1);
    check({nm, " busy low at done"}, {63'd0, busy}, 64'd0);
    check({nm, " product"}, product, exp);
    last_p = exp;
    @(negedge clk);
    check({nm, " done single"}, {63'd0, done}, 64'd0);
    check({nm, " product hold"}, product, exp);
  endtask

  // Main test sequence.
  initial begin
    int lat;
    logic [31:0] rx;
    logic [31:0] ry;
    logic        rs;
    logic [63:0] ref_p;
    longint      sa;
    longint      sb;
    passed = 0; total = 0; done_seen = 0; accepted = 0; last_p = 64'd0;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; a = 32'd0; b = 32'd0;

    vecs[0] = '{"u_ff_ff",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{"s_m3_5",    1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFFFFFFFFF1};
    vecs[2] = '{"s_min_min", 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[3] = '{"s_m1_m1",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vecs[4] = '{"s_min_1",   1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF80000000};
    vecs[5] = '{"u_zero",    1'b0, 32'd0,        32'hDEADBEEF, 64'd0};
    vecs[6] = '{"u_12345",   1'b0, 32'd12345,    32'd6789,     64'd83810205};
    vecs[7] = '{"u_min_2",   1'b0, 32'h80000000, 32'd2,        64'h0000000100000000};
    vecs[8] = '{"s_7_m9",    1'b1, 32'd7,        32'hFFFFFFF7, 64'hFFFFFFFFFFFFFFC1};
    vecs[9] = '{"u_m1_as_u", 1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000FFFFFFFF};

    // Reset, then five idle cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle product", product, 64'd0);
      check("idle busy", {63'd0, busy}, 64'd0);
      check("idle done", {63'd0, done}, 64'd0);
    end

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p, -1);
    end

    // Second start at E10 is ignored.
    run_op("ignored_start", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 10);

    // Reset at E15 of 12345*6789, with start also high at that edge.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; a = 32'd12345; b = 32'd6789;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset product", product, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    rst = 1'b0; start = 1'b0;
    last_p = 64'd0;
    lat = done_seen;
    repeat (40) @(negedge clk);
    check("no done after reset", 64'(done_seen), 64'(lat));
    check("idle after reset busy", {63'd0, busy}, 64'd0);
    run_op("after_reset_2x3", 1'b0, 32'd2, 32'd3, 64'd6, -1);

    // Back-to-back: start held in the done cycle is sampled at E34.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; a = 32'd11; b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    check("b2b first latency", 64'(lat), 64'd33);
    check("b2b first product", product, 64'd143);
    start = 1'b1; a = 32'd4; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("b2b accept busy", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    check("b2b second latency", 64'(lat), 64'd33);
    check("b2b second product", product, 64'd20);
    accepted += 2;
    last_p = 64'd20;

    // Random sweep in both modes against the native product.
    for (int i = 0; i < 200; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i % 8 == 0) rx = 32'h80000000;
      if (i % 11 == 0) ry = 32'hFFFFFFFF;
      rs = i[0];
      if (rs) begin
        sa = longint'($signed(rx));
        sb = longint'($signed(ry));
        ref_p = 64'(sa * sb);
      end else begin
        ref_p = {32'd0, rx} * {32'd0, ry};
      end
      run_op($sformatf("rand%0d", i), rs, rx, ry, ref_p, -1);
    end

    repeat (3) @(negedge clk);
    check("done pulse count", 64'(done_seen), 64'(accepted));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
